// File: rtl/qos_pkg.sv
// qos_pkg -- shared constants and types for the QoS memory-mapped register block.
//
// Contents:
//   - register addresses (CFG, STATUS, ERRCNT)
//   - CFG/STATUS field bit positions
//   - reset defaults for channel_priority and reset_timer
//   - cfg_t: packed view of the CFG word, laid out exactly as it appears on the bus
//
// Optional feature (selected in qos_mm_regs): QOS_MM_ERR_CLR_ON_READ_EN.
package qos_pkg;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 8;
    localparam int TIMER_W = 20;

    localparam logic [7:0] ADDR_CFG    = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h01;
    localparam logic [7:0] ADDR_ERRCNT = 8'h02;

    // CFG field positions
    localparam int CFG_FALLBACK_BIT  = 0;
    localparam int CFG_MANUAL_EN_BIT = 1;
    localparam int CFG_MANUAL_CH_LSB = 2;
    localparam int CFG_PRIO_LSB      = 4;
    localparam int CFG_TIMER_LSB     = 12;

    // STATUS field positions
    localparam int STATUS_ACTIVE_LSB  = 0;
    localparam int STATUS_PRESENT_LSB = 2;

    localparam logic [7:0]         QOS_DEF_PRIORITY  = 8'b11_10_01_00;
    localparam logic [TIMER_W-1:0] QOS_DEF_RST_TIMER = 20'd0;

    // Field order (MSB first) matches the positions above, so a cast from
    // the 32-bit bus word lands each field in place.
    typedef struct packed {
        logic [TIMER_W-1:0] reset_timer;
        logic [7:0]         channel_priority;
        logic [1:0]         manual_channel;
        logic               manual_enable;
        logic               fallback_enable;
    } cfg_t;

endpackage

// File: rtl/qos_err_counter.sv
// qos_err_counter -- one saturating per-channel error counter.
//
// Ports:
//   rclk   in   clock
//   rst    in   async active-high reset (count -> 0)
//   clr    in   synchronous clear; an inc in the same cycle is kept (count -> 1)
//   inc    in   one-cycle increment request
//   count  out  current count, sticks at all-ones
module qos_err_counter
    import qos_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         rclk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            // Clear must not swallow an error landing on the same cycle.
            count_reg <= {{(W-1){1'b0}}, inc};
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/qos_mm_regs.sv
// qos_mm_regs -- memory-mapped configuration/status registers for the QoS
// channel selector, with per-channel error counters and a periodic window
// timer that clears them.
//
// Register map:
//   0x00 CFG    rw  {reset_timer, channel_priority, manual_channel, manual_enable, fallback_enable}
//   0x01 STATUS ro  {26'b0, signal_present, active_channel}
//   0x02 ERRCNT ro  {cnt3, cnt2, cnt1, cnt0}
//   others          read 0, writes ignored
//
// Ports:
//   rclk, rst                         clock, async active-high reset
//   mm_write_en, mm_read_en           bus strobes
//   mm_addr[7:0], mm_wdata[31:0]      bus address / write data
//   mm_rdata[31:0]                    read data, 1-cycle latency, held until next read
//   active_channel[1:0]               selector status input
//   signal_present[3:0]               per-channel presence input
//   err_pulse[3:0]                    per-channel error events
//   fallback_enable, manual_enable,
//   manual_channel, channel_priority,
//   reset_timer                       CFG fields
//   en_reset_counter                  one-cycle window-expiry pulse
//
// Build option: define QOS_MM_ERR_CLR_ON_READ_EN to make a read of ERRCNT
// clear all error counters (mm_rdata still returns the pre-clear values).
module qos_mm_regs
    import qos_pkg::*;
#(
    parameter logic [7:0]         DEF_PRIORITY  = QOS_DEF_PRIORITY,
    parameter logic [TIMER_W-1:0] DEF_RST_TIMER = QOS_DEF_RST_TIMER
) (
    input  logic               rclk,
    input  logic               rst,
    input  logic               mm_write_en,
    input  logic               mm_read_en,
    input  logic [7:0]         mm_addr,
    input  logic [31:0]        mm_wdata,
    output logic [31:0]        mm_rdata,
    input  logic [1:0]         active_channel,
    input  logic [3:0]         signal_present,
    input  logic [3:0]         err_pulse,
    output logic               fallback_enable,
    output logic               manual_enable,
    output logic [1:0]         manual_channel,
    output logic [7:0]         channel_priority,
    output logic [TIMER_W-1:0] reset_timer,
    output logic               en_reset_counter
);

    cfg_t               cfg_reg;
    logic [TIMER_W-1:0] win_reg;
    logic [TIMER_W-1:0] win_next;
    logic [31:0]        rdata_reg;
    logic [31:0]        rdata_next;
    logic               cfg_wr;
    logic               expire;
    logic               cnt_clr;
    logic [CNT_W-1:0]   err_cnt [NUM_CH];
    cfg_t               wr_cfg;

    assign cfg_wr = mm_write_en && (mm_addr == ADDR_CFG);
    assign wr_cfg = cfg_t'(mm_wdata);

    // ---------------- CFG register ----------------
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            cfg_reg.reset_timer      <= DEF_RST_TIMER;
            cfg_reg.channel_priority <= DEF_PRIORITY;
            cfg_reg.manual_channel   <= 2'b00;
            cfg_reg.manual_enable    <= 1'b0;
            cfg_reg.fallback_enable  <= 1'b0;
        end else if (cfg_wr) begin
            cfg_reg <= wr_cfg;
        end
    end

    // ---------------- window down-counter ----------------
    // Counts reset_timer..1; expiry is decoded from the registered count, so
    // the pulse lasts exactly the cycle the counter sits at 1. A zero count
    // with a non-zero timer (e.g. right after reset) just loads the timer.
    assign expire = (win_reg == TIMER_W'(1)) && (cfg_reg.reset_timer != '0);

    always_comb begin
        win_next = win_reg;
        if (cfg_wr) begin
            win_next = wr_cfg.reset_timer;
        end else if (cfg_reg.reset_timer == '0) begin
            win_next = '0;
        end else if (win_reg <= TIMER_W'(1)) begin
            win_next = cfg_reg.reset_timer;
        end else begin
            win_next = win_reg - 1'b1;
        end
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            win_reg <= '0;
        end else begin
            win_reg <= win_next;
        end
    end

    // ---------------- error counters ----------------
`ifdef QOS_MM_ERR_CLR_ON_READ_EN
    assign cnt_clr = expire || (mm_read_en && (mm_addr == ADDR_ERRCNT));
`else
    assign cnt_clr = expire;
`endif

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_err
            qos_err_counter #(
                .W(CNT_W)
            ) u_err_counter (
                .rclk  (rclk),
                .rst   (rst),
                .clr   (cnt_clr),
                .inc   (err_pulse[gi]),
                .count (err_cnt[gi])
            );
        end
    endgenerate

    // ---------------- read path ----------------
    // Registered read of the current (pre-edge) state, so a same-cycle CFG
    // write or counter clear is not yet visible in the returned word.
    always_comb begin
        rdata_next = 32'h0;
        case (mm_addr)
            ADDR_CFG:    rdata_next = cfg_reg;
            ADDR_STATUS: rdata_next = {26'b0, signal_present, active_channel};
            ADDR_ERRCNT: rdata_next = {err_cnt[3], err_cnt[2], err_cnt[1], err_cnt[0]};
            default:     rdata_next = 32'h0;
        endcase
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (mm_read_en) begin
            rdata_reg <= rdata_next;
        end
    end

    // ---------------- outputs ----------------
    assign mm_rdata         = rdata_reg;
    assign fallback_enable  = cfg_reg.fallback_enable;
    assign manual_enable    = cfg_reg.manual_enable;
    assign manual_channel   = cfg_reg.manual_channel;
    assign channel_priority = cfg_reg.channel_priority;
    assign reset_timer      = cfg_reg.reset_timer;
    assign en_reset_counter = expire;

endmodule

// File: tb/tb_qos_mm_regs.sv
// tb_qos_mm_regs -- randomized, scoreboard-checked bench for qos_mm_regs.
// The driver updates a behavioural model every cycle and queues the expected
// post-edge view; a monitor pops one entry per clock and compares.
module tb_qos_mm_regs;
    import qos_pkg::*;

`ifdef QOS_MM_ERR_CLR_ON_READ_EN
    localparam bit CLR_ON_READ = 1'b1;
`else
    localparam bit CLR_ON_READ = 1'b0;
`endif

    logic        rclk = 1'b0;
    logic        rst;
    logic        mm_write_en, mm_read_en;
    logic [7:0]  mm_addr;
    logic [31:0] mm_wdata, mm_rdata;
    logic [1:0]  active_channel;
    logic [3:0]  signal_present, err_pulse;
    logic        fallback_enable, manual_enable;
    logic [1:0]  manual_channel;
    logic [7:0]  channel_priority;
    logic [19:0] reset_timer;
    logic        en_reset_counter;

    always #5 rclk = ~rclk;

    qos_mm_regs dut (
        .rclk             (rclk),
        .rst              (rst),
        .mm_write_en      (mm_write_en),
        .mm_read_en       (mm_read_en),
        .mm_addr          (mm_addr),
        .mm_wdata         (mm_wdata),
        .mm_rdata         (mm_rdata),
        .active_channel   (active_channel),
        .signal_present   (signal_present),
        .err_pulse        (err_pulse),
        .fallback_enable  (fallback_enable),
        .manual_enable    (manual_enable),
        .manual_channel   (manual_channel),
        .channel_priority (channel_priority),
        .reset_timer      (reset_timer),
        .en_reset_counter (en_reset_counter)
    );

    typedef struct {
        bit          chk_rd;
        logic [7:0]  addr;
        logic [31:0] rd;
        logic [31:0] cfg;
        bit          pulse;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Behavioural model
    logic [31:0] m_cfg;
    int          m_cnt [4];
    longint      cyc;
    longint      m_start;

    function automatic bit pulse_at(longint c);
        longint t;
        t = longint'(m_cfg[31:12]);
        if (t == 0 || c < m_start) return 1'b0;
        return ((c - m_start) % t) == (t - 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [31:0] dut_cfg();
        return {reset_timer, channel_priority, manual_channel, manual_enable, fallback_enable};
    endfunction

    task automatic step(input logic we, input logic re, input logic [7:0] a,
                        input logic [31:0] wd, input logic [1:0] ac,
                        input logic [3:0] sp, input logic [3:0] er);
        exp_t e;
        bit   p, clr;
        @(negedge rclk);
        mm_write_en = we; mm_read_en = re; mm_addr = a; mm_wdata = wd;
        active_channel = ac; signal_present = sp; err_pulse = er;

        e.chk_rd = re;
        e.addr   = a;
        case (a)
            8'h00:   e.rd = m_cfg;
            8'h01:   e.rd = {26'b0, sp, ac};
            8'h02:   e.rd = {m_cnt[3][7:0], m_cnt[2][7:0], m_cnt[1][7:0], m_cnt[0][7:0]};
            default: e.rd = 32'h0;
        endcase

        p   = pulse_at(cyc);
        clr = p || (CLR_ON_READ && re && a == 8'h02);
        for (int i = 0; i < 4; i++) begin
            if (clr)                         m_cnt[i] = er[i] ? 1 : 0;
            else if (er[i] && m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
        end
        if (we && a == 8'h00) begin
            m_cfg   = wd;
            m_start = cyc + 1;
        end
        cyc++;
        e.cfg   = m_cfg;
        e.pulse = pulse_at(cyc);
        sb.push_back(e);
    endtask

    task automatic idle(input int n, input logic [3:0] er);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 32'h0, 2'b00, 4'b0000, er);
    endtask

    // Monitor: one expected entry per clock edge, checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge rclk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("cfg_outputs", dut_cfg(), e.cfg);
                chk("en_reset_counter", {31'b0, en_reset_counter}, {31'b0, e.pulse});
                if (e.chk_rd) begin
                    $display("rd addr=%h data=%h expect=%h", e.addr, mm_rdata, e.rd);
                    chk("mm_rdata", mm_rdata, e.rd);
                end
            end
        end
    end

    initial begin
        logic [31:0] wd;
        m_cfg   = 32'h0000_0E40;
        m_start = 0;
        cyc     = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;

        rst = 1'b1;
        mm_write_en = 0; mm_read_en = 0; mm_addr = 0; mm_wdata = 0;
        active_channel = 0; signal_present = 0; err_pulse = 0;
        repeat (3) @(posedge rclk);
        #1;
        chk("reset_rdata", mm_rdata, 32'h0);
        chk("reset_cfg", dut_cfg(), 32'h0000_0E40);
        chk("reset_pulse", {31'b0, en_reset_counter}, 32'h0);
        @(negedge rclk);
        rst = 1'b0;

        // Reset-state read of CFG
        step(0, 1, 8'h00, 0, 0, 0, 0);
        // CFG write, same-cycle write+read returns old word, then readback
        wd = {20'd50000, 8'hD8, 2'b10, 1'b1, 1'b1};
        step(1, 1, 8'h00, wd, 0, 0, 0);
        step(0, 1, 8'h00, 0, 0, 0, 0);
        // STATUS
        step(0, 1, 8'h01, 0, 2'd2, 4'b1011, 0);
        // Saturation: timer off, 300 pulses on channel 1, read twice
        step(1, 0, 8'h00, {20'd0, 8'hD8, 2'b10, 1'b1, 1'b1}, 0, 0, 0);
        idle(300, 4'b0010);
        step(0, 1, 8'h02, 0, 0, 0, 0);
        step(0, 1, 8'h02, 0, 0, 0, 0);
        // Window of 5; error on the pulse cycle, then read counters
        step(1, 0, 8'h00, {20'd5, 8'hE4, 4'b0000}, 0, 0, 0);
        idle(4, 4'b0000);
        step(0, 0, 8'h00, 0, 0, 0, 4'b0001);
        step(0, 1, 8'h02, 0, 0, 0, 0);
        idle(12, 4'b0100);
        // Ignored write, unmapped read
        step(1, 0, 8'h01, 32'hFFFF_FFFF, 0, 0, 0);
        step(0, 1, 8'h00, 0, 0, 0, 0);
        step(0, 1, 8'h05, 0, 0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            logic        we, re;
            logic [3:0]  er;
            we = ($urandom_range(0, 9) == 0);
            re = ($urandom_range(0, 2) == 0);
            wd = $urandom;
            if ($urandom_range(0, 3) != 0) wd[31:12] = 20'($urandom_range(0, 12));
            er = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
            step(we, re, 8'($urandom_range(0, 5)), wd,
                 2'($urandom), 4'($urandom), er);
        end
        idle(3, 4'b0000);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge rclk);
        #2;
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qos_mm_regs.md
QOS_MM_REGS -- requirements
Module: qos_mm_regs

Interface
- REQ-001 SHALL have parameter DEF_PRIORITY, default 8'b11_10_01_00, reset value of channel_priority.
- REQ-002 SHALL have parameter DEF_RST_TIMER, default 20'd0, reset value of reset_timer (0 = window timer disabled).
- REQ-003 SHALL use one clock and an asynchronous, active-high reset.
- REQ-004 SHALL have ports, clock and reset first:
  - rclk  in  1  system clock
  - rst  in  1  async active-high reset
  - mm_write_en  in  1  write strobe
  - mm_read_en  in  1  read strobe
  - mm_addr  in  8  register address
  - mm_wdata  in  32  write data
  - mm_rdata  out  32  registered read data
  - active_channel  in  2  current selected channel, from the selector
  - signal_present  in  4  per-channel presence
  - err_pulse  in  4  per-channel one-cycle TS error event
  - fallback_enable  out  1  cfg bit
  - manual_enable  out  1  cfg bit
  - manual_channel  out  2  cfg field
  - channel_priority  out  8  cfg field, 4x2-bit channel ids
  - reset_timer  out  20  cfg field
  - en_reset_counter  out  1  one-cycle window-expiry pulse

Function
- REQ-005 SHALL implement a register map:
  - 0x00 CFG rw {reset_timer[31:12], channel_priority[11:4], manual_channel[3:2], manual_enable[1], fallback_enable[0]}.
  - 0x01 STATUS ro {26'b0, signal_present[5:2], active_channel[1:0]}.
  - 0x02 ERRCNT ro {cnt3[31:24], cnt2[23:16], cnt1[15:8], cnt0[7:0]}.
- REQ-006 SHALL update CFG fields on the rclk edge sampling mm_write_en=1 with mm_addr=0x00; new values are visible on the outputs one cycle later.
- REQ-007 SHALL ignore writes to any address other than 0x00.
- REQ-008 SHALL load mm_rdata on the edge sampling mm_read_en=1 (1-cycle latency) and hold it until the next read.
- REQ-009 SHALL return 32'h0 for reads of unmapped addresses.
- REQ-010 SHALL give read priority to old data: a same-cycle write and read of 0x00 returns the pre-write CFG.
- REQ-011 SHALL keep 8-bit per-channel error counters, each incremented by err_pulse[i] and saturating at 8'hFF (no wrap).
- REQ-012 SHALL run a 20-bit window down-counter loaded with reset_timer.
  - At count 1 it asserts en_reset_counter for exactly one cycle, clears all error counters, and reloads.
- REQ-013 SHALL reload the window counter on every CFG write.
- REQ-014 SHALL hold the window counter at 0 and never pulse en_reset_counter while reset_timer==0.
- REQ-015 SHALL not lose an err_pulse coinciding with a counter clear: the counter becomes 1, otherwise 0.

Reset
- REQ-016 SHALL, on rst, asynchronously set:
  - mm_rdata=0, fallback_enable=0, manual_enable=0, manual_channel=0.
  - channel_priority=DEF_PRIORITY, reset_timer=DEF_RST_TIMER.
  - Counters and window counter 0, en_reset_counter=0.
- REQ-017 SHALL abort any in-progress window on rst; after release, the window starts from reload.

Configuration
- REQ-018 SHALL, with QOS_MM_ERR_CLR_ON_READ_EN defined, clear all error counters on the cycle a read of 0x02 is sampled, while mm_rdata captures the pre-clear values.
  - Without the macro, reads have no side effects.

Structure
- REQ-019 SHALL take register addresses, field bit positions and DEF_* defaults from shared package qos_pkg.
- REQ-020 SHALL instantiate sub-module qos_err_counter, one per channel: saturating counter with clear input.

Verification
- REQ-021 Reset release, read 0x00 -> mm_rdata=32'h0000_0E40 (priority 8'hE4).
- REQ-022 Write 0x00 with {20'd50000, 8'hD8, 2'b10, 1, 1} -> next cycle manual_channel=2, priority=8'hD8; read 0x00 returns the same word.
- REQ-023 active_channel=2, signal_present=4'b1011, read 0x01 -> mm_rdata=32'h0000_002E one cycle after the strobe.
- REQ-024 300 pulses on err_pulse[1], read 0x02 -> 32'h0000_FF00; with the macro, a second read -> 32'h0.
- REQ-025 reset_timer=5 -> en_reset_counter pulses every 5 cycles; an err_pulse on the pulse cycle leaves that counter at 1.
- REQ-026 Write to 0x01 with 32'hFFFF_FFFF -> no CFG change; read 0x05 -> 32'h0.
